ws2812_frame_scheduler: RTL and testbench
=========================================

# ws2812_frame_scheduler

Sits between `spi_in` and up to four `ws2812_out` channel engines. Decodes SPI register writes into per-channel pixel writes and a small control register file. Sequences frame transmission on all enabled channels: one-shot or periodic refresh, concurrent start, completion wait, latch gap. Provides a frame counter and a sticky timeout error.

## Interface
- `CHANNELS`, 4: number of ws2812 channel engines; 1..4.
- `LATCH_CYCLES`, 2400: low-time enforced after every frame; 50 us at 48 MHz.
- `TIMEOUT_CYCLES`, 4194304: maximum cycles allowed in WAIT_DONE.
- `clock` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low; asserted when 0.
- `spi_data` in 16: write data from `spi_in`.
- `spi_address` in 11: write address from `spi_in`.
- `spi_write_strobe` in 1: one-cycle write qualifier.
- `ch_data` out 16: forwarded pixel data.
- `ch_address` out 8: pixel word index within a channel.
- `ch_write_strobe` out CHANNELS: one-hot pixel write to a channel.
- `ch_start` out CHANNELS: one-cycle frame start per channel.
- `ch_length` out 9: words per frame, 1..256; held stable while `frame_active`.
- `ch_busy` in CHANNELS: channel transmitting.
- `frame_active` out 1: high from START through LATCH.
- `frame_count` out 16: completed frames; wraps 0xFFFF->0.
- `error` out 1: sticky; set on timeout; cleared by CTRL write with bit 15 = 1.

## Operation
- Address decode on `spi_write_strobe`:
  - addr[10]=0: pixel write to channel addr[9:8] at word addr[7:0].
  - If that channel number >= CHANNELS, the write is dropped.
  - addr[10]=1: control register addr[1:0]; addresses 3 and above are ignored.
- Registers and reset values:
  - CTRL (0): bit0 go (self-clearing); bit1 auto_refresh (0); bits[7:4] enable mask (0x1); bit15 error clear. Mask bits >= CHANNELS read as 0.
  - LENGTH (1): bits[8:0]; reset 0.
  - REFRESH (2): period in units of 256 cycles; reset 0xFFFF. Value 0 is treated as 1.
- Pixel forward: `ch_data`, `ch_address`, `ch_write_strobe` registered. Forwarding is unconditional, including mid-frame; tearing is accepted.
- Pending flag:
  - Set by a go write, or by refresh expiry while auto_refresh=1.
  - Multiple sets before service collapse into one.
  - Cleared when IDLE consumes it.
- Refresh counter: free-running while auto_refresh=1. Reloaded on expiry and on auto_refresh 0->1.
- FSM:
  - IDLE: if pending: if mask=0 or LENGTH=0, clear pending and stay in IDLE; otherwise latch mask and length, then go to START.
  - START: `ch_start` = latched mask for one cycle; go to WAIT_DONE.
  - WAIT_DONE: ignore `ch_busy` for the first 2 cycles. Then, when all latched-mask channels have `ch_busy`=0, go to LATCH.
  - WAIT_DONE timeout: if TIMEOUT_CYCLES elapse first, set `error` and go to LATCH.
  - LATCH: count LATCH_CYCLES; then increment `frame_count` and go to IDLE.
- Register writes during a frame take effect at the next IDLE consume. A go write during a frame sets pending; that frame starts after LATCH.
- Go write in the same cycle as refresh expiry: pending set once.
- Error clear in the same cycle as a timeout: the timeout wins and `error` stays 1.

## Timing
- Reset asserted: all outputs 0; FSM IDLE; pending 0; registers at reset values; effective immediately (asynchronous).
- Reset mid-frame: channels see `ch_start`=0 and no further commands; their own reset covers the rest.
- Pixel write: strobe in cycle N -> `ch_write_strobe` bit high in cycle N+1 only.
- Go write in cycle N, FSM in IDLE:
  - register/pending update at the end of N;
  - IDLE consumes in N+1;
  - `ch_start` and `frame_active` high in N+2.
- `frame_active` falls in the cycle after LATCH ends; `frame_count` updates on the same edge.
- Back-to-back frames: minimum gap from `frame_active` low to next `ch_start` is 1 cycle (IDLE).

## Test plan
- Pixel write addr 0x2A5, data 0xBEEF -> `ch_write_strobe`=0b0100, `ch_address`=0xA5, `ch_data`=0xBEEF, one cycle later, one cycle wide.
- LENGTH=10, mask=0x3, go; model channels busy for 100 cycles -> `ch_start`=0b0011 two cycles after the go strobe; `frame_active` spans START + WAIT_DONE + 2400; `frame_count` 0->1.
- Second go mid-frame plus a third go -> exactly one extra frame, starting 1 cycle after the first LATCH ends; `frame_count`=2.
- mask=0 go, and LENGTH=0 go -> no `ch_start`; `frame_count` unchanged; FSM stays in IDLE.
- auto_refresh=1, REFRESH=4 -> a frame starts every max(1024, frame length) cycles; `frame_count` increments continuously.
- Channel 1 busy stuck high, TIMEOUT_CYCLES=1000 -> `error`=1 after 1000 cycles, then LATCH and IDLE.
- Timeout recovery: error-clear write -> `error`=0.
- Reset dropped mid-LATCH -> all outputs 0 immediately; `frame_count`=0.

Source files
------------

// File: rtl/ws2812_frame_scheduler.sv
// Frame scheduler between the SPI register port and the ws2812 channel engines:
// forwards pixel writes, holds the control registers and sequences frame transmission.
module ws2812_frame_scheduler #(
  parameter int CHANNELS       = 4,
  parameter int LATCH_CYCLES   = 2400,
  parameter int TIMEOUT_CYCLES = 4194304
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         spi_data,
  input  logic [10:0]         spi_address,
  input  logic                spi_write_strobe,
  output logic [15:0]         ch_data,
  output logic [7:0]          ch_address,
  output logic [CHANNELS-1:0] ch_write_strobe,
  output logic [CHANNELS-1:0] ch_start,
  output logic [8:0]          ch_length,
  input  logic [CHANNELS-1:0] ch_busy,
  output logic                frame_active,
  output logic [15:0]         frame_count,
  output logic                error
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > LATCH_CYCLES) ? TIMEOUT_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, LATCH} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                pix_wr, ctrl_wr, len_wr, refr_wr;
  logic                go_set, err_clr, auto_rise, refr_expire, consume;
  logic                launch, timeout, frame_done;
  logic                auto_refresh, pending;
  logic [CHANNELS-1:0] en_mask, lat_mask;
  logic [8:0]          len_reg, lat_len;
  logic [15:0]         refresh_reg;
  logic [23:0]         refr_cnt, refr_reload;

  always_comb begin
    pix_wr    = spi_write_strobe && !spi_address[10] && (int'(spi_address[9:8]) < CHANNELS);
    ctrl_wr   = spi_write_strobe && spi_address[10] && (spi_address[1:0] == 2'd0);
    len_wr    = spi_write_strobe && spi_address[10] && (spi_address[1:0] == 2'd1);
    refr_wr   = spi_write_strobe && spi_address[10] && (spi_address[1:0] == 2'd2);
    go_set    = ctrl_wr && spi_data[0];
    err_clr   = ctrl_wr && spi_data[15];
    auto_rise = ctrl_wr && spi_data[1] && !auto_refresh;
    // A period of zero behaves as one unit of 256 cycles.
    refr_reload = {(refresh_reg == 16'd0) ? 16'd1 : refresh_reg, 8'h00} - 24'd1;
    refr_expire = auto_refresh && (refr_cnt == 24'd0);
    consume     = (state == IDLE) && pending;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch_data         <= '0;
      ch_address      <= '0;
      ch_write_strobe <= '0;
    end else begin
      ch_write_strobe <= '0;
      if (pix_wr) begin
        ch_data         <= spi_data;
        ch_address      <= spi_address[7:0];
        ch_write_strobe <= CHANNELS'(1) << spi_address[9:8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_refresh <= 1'b0;
      en_mask      <= CHANNELS'(1);
      len_reg      <= '0;
      refresh_reg  <= 16'hFFFF;
      refr_cnt     <= '0;
      pending      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        auto_refresh <= spi_data[1];
        en_mask      <= spi_data[4 +: CHANNELS];
      end
      if (len_wr)  len_reg     <= spi_data[8:0];
      if (refr_wr) refresh_reg <= spi_data;
      if (auto_rise || refr_expire) refr_cnt <= refr_reload;
      else if (auto_refresh)        refr_cnt <= refr_cnt - 24'd1;
      // New requests win over a consume in the same cycle; repeats collapse.
      pending <= go_set || refr_expire || (pending && !consume);
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    launch     = 1'b0;
    timeout    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pending && (en_mask != '0) && (len_reg != 9'd0)) begin
          launch    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Engines may not raise busy until a couple of cycles after start.
        cnt_nxt = cnt + 1'b1;
        if ((cnt >= CNT_W'(2)) && ((ch_busy & lat_mask) == '0)) begin
          cnt_nxt   = '0;
          state_nxt = LATCH;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
          frame_done = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_mask    <= '0;
      lat_len     <= '0;
      frame_count <= '0;
      error       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (launch) begin
        lat_mask <= en_mask;
        lat_len  <= len_reg;
      end
      if (frame_done) frame_count <= frame_count + 16'd1;
      error <= timeout || (error && !err_clr);
    end
  end

  always_comb begin
    frame_active = (state != IDLE);
    ch_start     = (state == START) ? lat_mask : '0;
    ch_length    = lat_len;
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Bench for ws2812_frame_scheduler: directed and randomized SPI traffic against
// a frame-level reference model with behavioural channel engines.
module tb_ws2812_frame_scheduler;
  localparam int CH  = 3;
  localparam int LAT = 50;
  localparam int TO  = 1000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   spi_data = '0;
  logic [10:0]   spi_address = '0;
  logic          spi_write_strobe = 1'b0;
  logic [15:0]   ch_data;
  logic [7:0]    ch_address;
  logic [CH-1:0] ch_write_strobe, ch_start, ch_busy;
  logic [8:0]    ch_length;
  logic          frame_active;
  logic [15:0]   frame_count;
  logic          error;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_fc = 0;
  int starts[$];
  int busy_len [CH];
  int busy_cnt [CH];
  logic [CH-1:0] stuck = '0;

  ws2812_frame_scheduler #(.CHANNELS(CH), .LATCH_CYCLES(LAT), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .spi_data(spi_data), .spi_address(spi_address),
    .spi_write_strobe(spi_write_strobe), .ch_data(ch_data), .ch_address(ch_address),
    .ch_write_strobe(ch_write_strobe), .ch_start(ch_start), .ch_length(ch_length),
    .ch_busy(ch_busy), .frame_active(frame_active), .frame_count(frame_count), .error(error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (ch_start != '0) starts.push_back(cyc);

  // Channel engine model: busy for busy_len cycles after its start pulse.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) busy_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < CH; i++)
        if (ch_start[i])        busy_cnt[i] <= busy_len[i];
        else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end

  always_comb begin
    ch_busy = '0;
    for (int i = 0; i < CH; i++) ch_busy[i] = stuck[i] || (busy_cnt[i] != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Strobe is driven for the clock cycle in which the task is entered.
  task automatic spi_wr(input logic [10:0] a, input logic [15:0] d);
    spi_address      = a;
    spi_data         = d;
    spi_write_strobe = 1'b1;
    @(negedge clock);
    spi_write_strobe = 1'b0;
  endtask

  // Cycles with frame_active high: START, WAIT_DONE (at least 3, at most TO), LATCH.
  function automatic int exp_active(input int b);
    int w;
    w = (b < 2) ? 2 : b;
    if (w <= TO - 1) return 1 + (w + 1) + LAT;
    return 1 + TO + LAT;
  endfunction

  task automatic wait_idle(input string tag);
    int k = 0;
    while (frame_active && k < 5000) begin
      @(negedge clock);
      k++;
    end
    check(tag, frame_active, 0);
  endtask

  task automatic do_frame(input logic [3:0] mf, input logic [8:0] len, input int fixed_busy);
    logic [CH-1:0] m;
    int bmax = 0;
    int n = 0;
    m = mf[CH-1:0];
    for (int i = 0; i < CH; i++) begin
      busy_len[i] = (fixed_busy >= 0) ? fixed_busy : $urandom_range(0, 300);
      if (m[i] && busy_len[i] > bmax) bmax = busy_len[i];
    end
    spi_wr(11'h401, {7'd0, len});
    spi_wr(11'h400, {8'd0, mf, 4'h1});
    check("start_early", ch_start, 0);
    @(negedge clock);
    check("start_mask", ch_start, m);
    check("active_rise", frame_active, 1);
    check("length", ch_length, len);
    do begin
      @(negedge clock);
      n++;
    end while (frame_active && n < 5000);
    check("active_len", n, exp_active(bmax));
    exp_fc++;
    check("frame_count", frame_count, exp_fc);
  endtask

  task automatic no_frame(input string tag, input logic [10:0] a, input logic [15:0] d);
    starts.delete();
    spi_wr(a, d);
    tick(6);
    check(tag, starts.size(), 0);
    check({tag, "_idle"}, frame_active, 0);
  endtask

  initial begin
    logic [9:0]    a;
    logic [15:0]   d;
    logic [CH-1:0] es;
    logic [15:0]   last_d;
    logic [7:0]    last_a;
    logic [3:0]    mf;
    int            wc, k;

    for (int i = 0; i < CH; i++) busy_len[i] = 0;
    tick(3);
    check("rst_start", ch_start, 0);
    check("rst_active", frame_active, 0);
    check("rst_count", frame_count, 0);
    check("rst_error", error, 0);
    check("rst_wstrobe", ch_write_strobe, 0);
    check("rst_length", ch_length, 0);
    reset = 1'b1;
    tick(2);

    spi_wr(11'h2A5, 16'hBEEF);
    check("pix_strobe", ch_write_strobe, 3'b100);
    check("pix_addr", ch_address, 8'hA5);
    check("pix_data", ch_data, 16'hBEEF);
    @(negedge clock);
    check("pix_strobe_width", ch_write_strobe, 0);
    last_d = 16'hBEEF;
    last_a = 8'hA5;
    repeat (12) begin
      a = 10'($urandom_range(0, 1023));
      d = 16'($urandom);
      spi_wr({1'b0, a}, d);
      es = '0;
      if (int'(a[9:8]) < CH) begin
        es     = CH'(1) << a[9:8];
        last_d = d;
        last_a = a[7:0];
      end
      check("pix_rnd_strobe", ch_write_strobe, es);
      check("pix_rnd_addr", ch_address, last_a);
      check("pix_rnd_data", ch_data, last_d);
    end

    do_frame(4'h3, 9'd10, 100);
    repeat (4) begin
      do mf = 4'($urandom); while (mf[CH-1:0] == '0);
      do_frame(mf, 9'($urandom_range(1, 256)), -1);
    end

    for (int i = 0; i < CH; i++) busy_len[i] = 40;
    starts.delete();
    spi_wr(11'h401, 16'd20);
    spi_wr(11'h400, 16'h0031);
    tick(5);
    spi_wr(11'h400, 16'h0031);
    tick(3);
    spi_wr(11'h400, 16'h0031);
    tick(400);
    check("mid_go_starts", starts.size(), 2);
    if (starts.size() == 2) check("mid_go_gap", starts[1] - starts[0], exp_active(40) + 1);
    exp_fc += 2;
    check("mid_go_count", frame_count, exp_fc);

    no_frame("mask0", 11'h400, 16'h0001);
    no_frame("mask_unimpl", 11'h400, 16'h0081);
    no_frame("ctrl3_ignored", 11'h403, 16'h0011);
    spi_wr(11'h401, 16'd0);
    no_frame("len0", 11'h400, 16'h0011);
    check("empty_count", frame_count, exp_fc);

    for (int i = 0; i < CH; i++) busy_len[i] = $urandom_range(0, 300);
    spi_wr(11'h401, 16'd33);
    spi_wr(11'h402, 16'd4);
    starts.delete();
    wc = cyc;
    spi_wr(11'h400, 16'h0032);
    k = 0;
    while (starts.size() < 4 && k < 6000) begin
      tick(1);
      k++;
    end
    check("auto_frames", starts.size(), 4);
    if (starts.size() >= 4) begin
      check("auto_first", starts[0] - wc, 1026);
      for (int j = 1; j < 4; j++) check("auto_period", starts[j] - starts[j-1], 1024);
    end
    spi_wr(11'h400, 16'h0030);
    wait_idle("auto_idle");
    exp_fc += 4;
    check("auto_count", frame_count, exp_fc);
    tick(1200);
    check("auto_off", starts.size(), 4);

    stuck = 3'b010;
    spi_wr(11'h401, 16'd8);
    spi_wr(11'h400, 16'h0021);
    @(negedge clock);
    check("to_start", ch_start, 3'b010);
    tick(TO);
    check("to_not_yet", error, 0);
    tick(1);
    check("to_error", error, 1);
    check("to_latch", frame_active, 1);
    tick(LAT);
    check("to_idle", frame_active, 0);
    exp_fc++;
    check("to_count", frame_count, exp_fc);
    spi_wr(11'h400, 16'h8020);
    check("err_clear", error, 0);

    spi_wr(11'h400, 16'h0021);
    @(negedge clock);
    check("race_start", ch_start, 3'b010);
    tick(TO);
    spi_wr(11'h400, 16'h8020);
    check("clr_vs_timeout", error, 1);
    wait_idle("race_idle");
    exp_fc++;
    check("race_count", frame_count, exp_fc);
    spi_wr(11'h400, 16'h8020);
    check("err_clear2", error, 0);
    stuck = '0;

    for (int i = 0; i < CH; i++) busy_len[i] = 10;
    spi_wr(11'h401, 16'd5);
    spi_wr(11'h400, 16'h0011);
    @(negedge clock);
    tick(18);
    spi_wr(11'h0A5, 16'h1234);
    check("pre_rst_latch", frame_active, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_active", frame_active, 0);
    check("arst_start", ch_start, 0);
    check("arst_count", frame_count, 0);
    check("arst_error", error, 0);
    check("arst_length", ch_length, 0);
    check("arst_data", ch_data, 0);
    check("arst_addr", ch_address, 0);
    check("arst_wstrobe", ch_write_strobe, 0);
    @(negedge clock);
    reset = 1'b1;
    exp_fc = 0;
    tick(2);
    no_frame("rst_len_zero", 11'h400, 16'h0011);
    do_frame(4'h1, 9'd5, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
